// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector result readout path.
package mv_pkg;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int calc_rw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction
endpackage

// File: rtl/mv_rd_fifo.sv
// Two-entry synchronous FIFO carrying {last, data}; the head sits in a register.
module mv_rd_fifo
    import mv_pkg::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic         push_ok,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         head_last
);
    logic [W-1:0] tail_data;
    logic         tail_last;
    logic         do_push;
    logic         do_pop;

    assign push_ok    = count < 2'(FIFO_DEPTH);
    assign head_valid = count != 2'd0;
    assign do_push    = push && push_ok;
    assign do_pop     = pop && head_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands wherever the queue now ends.
                    if (count == 2'd1) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mv_result_reader.sv
// Streams N consecutive result-RAM words out as valid/ready beats with a last marker.
module mv_result_reader
    import mv_pkg::*;
#(
    parameter int N          = 3,
    parameter int DW         = 8,
    parameter int BRAM_DEPTH = 32,
    parameter int AW         = calc_aw(BRAM_DEPTH),
    parameter int RW         = calc_rw(DW, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [RW-1:0] rd_data,
    output logic [RW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] issued;
    logic [CW-1:0] pushed;
    logic [AW-1:0] addr;
    logic          inflight;
    logic          pop;
    logic          issue;
    logic          push_ok;
    logic [1:0]    count;
    logic [2:0]    occ;

    assign pop = out_valid && out_ready;
    assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

    // rd_en is decoded from registered state plus this cycle's accept, so a slot
    // freed by the consumer is reused immediately and streaming stays at 1 word/cycle.
    assign issue   = (state == READ) && (issued < N_C) && (occ < 3'(FIFO_DEPTH));
    assign rd_en   = issue;
    assign rd_addr = addr;
    assign busy    = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            issued   <= '0;
            pushed   <= '0;
            addr     <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= 1'b0;
            if (inflight && push_ok)
                pushed <= pushed + 1'b1;
            case (state)
                IDLE: if (start) begin
                    addr   <= base_addr;
                    issued <= '0;
                    pushed <= '0;
                    state  <= READ;
                end
                READ: begin
                    if (issue) begin
                        issued <= issued + 1'b1;
                        addr   <= (addr == AW'(BRAM_DEPTH - 1)) ? '0 : addr + 1'b1;
                    end
                    if (issued == N_C)
                        state <= DRAIN;
                end
                default: ;
            endcase
            if (pop && out_last && state != IDLE) begin
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end

    mv_rd_fifo #(.W(RW)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (rd_data),
        .push_last  (pushed == LAST_C),
        .pop        (out_ready),
        .push_ok    (push_ok),
        .count      (count),
        .head_valid (out_valid),
        .head_data  (out_data),
        .head_last  (out_last)
    );
endmodule

// File: tb/tb_mv_result_reader.sv
// Randomized bench for mv_result_reader against a queue-style readout model.
module tb_mv_result_reader;
    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RW    = 2 * DW + $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data = '0;
    logic [RW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [RW-1:0] ram [DEPTH];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model state
    bit            mon_on     = 0;
    bit            m_busy     = 0;
    bit            done_exp   = 0;
    bit            seen_done  = 0;
    bit            prev_stall = 0;
    bit            allrdy     = 0;
    logic [RW-1:0] prev_data;
    logic          prev_last;
    int            m_base = 0, iss = 0, acc = 0, start_cyc = 0;

    mv_result_reader #(.N(N), .DW(DW), .BRAM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit pop, last_acc;
        if (mon_on) begin
            chk("busy", busy, m_busy);
            chk("done", done, done_exp);
            if (rd_en) begin
                chk("rd_in_busy", m_busy, 1);
                chk("rd_count", iss < N, 1);
                chk("rd_addr", rd_addr, (m_base + iss) % DEPTH);
                if (iss == 0) chk("rd_latency", cyc, start_cyc + 1);
                iss++;
            end
            if (out_valid) chk("valid_in_busy", m_busy, 1);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            pop = out_valid && out_ready;
            if (pop) begin
                chk("beat_data", out_data, ram[(m_base + acc) % DEPTH]);
                chk("beat_last", out_last, acc == N - 1);
                acc++;
            end
            chk("outstanding", (iss - acc) <= 2, 1);
            prev_stall = out_valid && !out_ready && !rst;
            prev_data  = out_data;
            prev_last  = out_last;
            if (!out_ready) allrdy = 0;
            last_acc = pop && m_busy && (acc == N);
            if (last_acc && allrdy) chk("throughput", cyc, start_cyc + N + 2);
            done_exp = last_acc;
            if (last_acc) m_busy = 0;
            else if (!m_busy && start) begin
                m_busy = 1; m_base = base_addr; iss = 0; acc = 0;
                start_cyc = cyc; allrdy = 1;
            end
            if (rst) begin
                m_busy = 0; done_exp = 0; iss = 0; acc = 0; prev_stall = 0;
            end
            if (done) seen_done = 1;
        end
    end

    // mode 0: ready high; mode 1: ready low for cycles lo..hi; mode 2: random ready
    task automatic readout(input int base, input int mode, input int lo, input int hi,
                           input int xs_off, input int xs_base, input int rst_off);
        int  k   = 0;
        bit  fin = 0;
        seen_done = 0;
        start     = 1'b1;
        base_addr = AW'(base);
        out_ready = (mode == 2) ? 1'($urandom) : 1'b1;
        while (!fin) begin
            @(posedge clk); #1;
            k++;
            start     = (k == xs_off);
            base_addr = (k == xs_off) ? AW'(xs_base) : AW'($urandom);
            rst       = (k == rst_off);
            case (mode)
                1:       out_ready = !(k >= lo && k <= hi);
                2:       out_ready = 1'($urandom);
                default: out_ready = 1'b1;
            endcase
            if (seen_done || (rst_off > 0 && k == rst_off + 1)) fin = 1;
            if (k > 300) begin
                chk("timeout", k, 300);
                fin = 1;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_off > 0) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_valid", out_valid, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = RW'($urandom);
        rst = 1'b1; start = 1'b0; base_addr = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_last", out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        mon_on = 1;
        @(posedge clk); #1;

        ram[0] = 5; ram[1] = 7; ram[2] = 9;
        readout(0, 0, 0, 0, -1, 0, -1);          // basic
        readout(0, 1, 3, 6, -1, 0, -1);          // backpressure
        ram[30] = 1; ram[31] = 2; ram[0] = 3;
        readout(30, 0, 0, 0, -1, 0, -1);         // address wrap
        ram[0] = 5;
        ram[10] = 11; ram[11] = 12; ram[12] = 13;
        readout(0, 0, 0, 0, 2, 10, -1);          // start while busy ignored
        readout(10, 0, 0, 0, -1, 0, -1);
        readout(0, 0, 0, 0, -1, 0, 4);           // reset mid-readout
        readout(0, 0, 0, 0, -1, 0, -1);
        for (int i = 0; i < N; i++) ram[i] = '1;
        readout(0, 1, 2, 4, -1, 0, -1);          // all-ones data

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = RW'($urandom);
            readout(int'($urandom_range(0, DEPTH - 1)), 2, 0, 0,
                    int'($urandom_range(1, 6)), int'($urandom_range(0, DEPTH - 1)), -1);
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
